// File: rtl/mem_if_pkg.sv
// ----------------------------------------------------------------------------
// mem_if_pkg
// Shared types and constants for the MAR/MDR memory interface stage.
//   state_t            : transaction sequencer states
//   MEM_READ/MEM_WRITE : encoding of mem_rw
//   DEF_DATA_W/ADDR_W  : default word and RAM address widths
// ----------------------------------------------------------------------------
package mem_if_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 8;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_CAP,
        WR,
        DONE
    } state_t;

endpackage

// File: rtl/mem_interface_if.sv
// ----------------------------------------------------------------------------
// mem_interface_if
// CPU-side handshake and bus signals of the memory interface stage.
//   bus_in, mar_in, mdr_in    : datapath bus value and register load strobes
//   mem_req, mem_rw           : transaction request strobe and direction
//   mem_busy, mem_done,
//   mem_err, mdr_out          : status pulses and MDR contents back to the bus
// Modports: master = CPU/datapath side, slave = mem_interface.
// ----------------------------------------------------------------------------
interface mem_interface_if #(
    parameter int unsigned DATA_W = mem_if_pkg::DEF_DATA_W
) ();

    logic [DATA_W-1:0] bus_in;
    logic              mar_in;
    logic              mdr_in;
    logic              mem_req;
    logic              mem_rw;
    logic              mem_busy;
    logic              mem_done;
    logic              mem_err;
    logic [DATA_W-1:0] mdr_out;

    modport master (
        output bus_in, mar_in, mdr_in, mem_req, mem_rw,
        input  mem_busy, mem_done, mem_err, mdr_out
    );

    modport slave (
        input  bus_in, mar_in, mdr_in, mem_req, mem_rw,
        output mem_busy, mem_done, mem_err, mdr_out
    );

endinterface

// File: rtl/reg_en.sv
// ----------------------------------------------------------------------------
// reg_en
// DATA_W-wide register with synchronous clear and load enable (MAR / MDR).
//   clk  : rising-edge clock
//   clr  : synchronous active-high clear, dominates i_en
//   i_en : load i_d at the edge
//   i_d  : load value
//   o_q  : register contents
// ----------------------------------------------------------------------------
module reg_en #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mem_interface.sv
// ----------------------------------------------------------------------------
// mem_interface
// MAR/MDR stage in front of a 256-word synchronous-read RAM. Latches address
// and data from the datapath bus, sequences single read/write transactions
// under a req/done handshake and returns read data through MDR.
//   clk      : rising-edge clock
//   clr      : synchronous active-high reset
//   bus      : mem_interface_if.slave (bus_in, load strobes, req/rw, status)
//   ram_addr : low ADDR_W bits of MAR
//   ram_din  : MDR
//   ram_we   : RAM write enable, high only in WR and never on a reset edge
//   ram_dout : RAM read data, valid one edge after the address is registered
// Optional: define MEM_BOUNDS_CHECK_EN to reject requests whose MAR has any
// bit set above ADDR_W (mem_done + mem_err, RAM and MDR untouched).
// ----------------------------------------------------------------------------
module mem_interface
    import mem_if_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                clr,
    mem_interface_if.slave      bus,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_din,
    output logic                ram_we,
    input  logic [DATA_W-1:0]   ram_dout
);

    state_t            r_state;
    logic              r_err;

    logic              w_idle;
    logic              w_mar_en;
    logic              w_mdr_en;
    logic [DATA_W-1:0] w_mdr_d;
    logic [DATA_W-1:0] w_mar;
    logic [DATA_W-1:0] w_mdr;
    logic              w_oob;

    // Loads are honoured only in IDLE so MAR/MDR stay stable while busy
    assign w_idle   = (r_state == IDLE);
    assign w_mar_en = w_idle & bus.mar_in;
    assign w_mdr_en = (w_idle & bus.mdr_in) | (r_state == RD_CAP);
    assign w_mdr_d  = (r_state == RD_CAP) ? ram_dout : bus.bus_in;

    reg_en #(.DATA_W(DATA_W)) u_mar (
        .clk  (clk),
        .clr  (clr),
        .i_en (w_mar_en),
        .i_d  (bus.bus_in),
        .o_q  (w_mar)
    );

    reg_en #(.DATA_W(DATA_W)) u_mdr (
        .clk  (clk),
        .clr  (clr),
        .i_en (w_mdr_en),
        .i_d  (w_mdr_d),
        .o_q  (w_mdr)
    );

`ifdef MEM_BOUNDS_CHECK_EN
    // Check the MAR value the transaction will actually use, including a
    // load arriving in the same cycle as the request
    logic [DATA_W-1:0] w_mar_next;
    assign w_mar_next = w_mar_en ? bus.bus_in : w_mar;
    assign w_oob      = |w_mar_next[DATA_W-1:ADDR_W];
`else
    // Upper MAR bits are stored but never reach the RAM
    logic w_unused_mar_hi;
    assign w_unused_mar_hi = ^w_mar[DATA_W-1:ADDR_W];
    assign w_oob           = 1'b0;
`endif

    // Transaction sequencer
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.mem_req) begin
                        if (w_oob) begin
                            r_state <= DONE;
                            r_err   <= 1'b1;
                        end else if (bus.mem_rw == MEM_WRITE) begin
                            r_state <= WR;
                        end else begin
                            r_state <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: r_state <= RD_CAP;
                RD_CAP:  r_state <= DONE;
                WR:      r_state <= DONE;
                DONE: begin
                    r_state <= IDLE;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_busy = (r_state != IDLE);
    assign bus.mem_done = (r_state == DONE);
    assign bus.mem_err  = r_err;
    assign bus.mdr_out  = w_mdr;

    // Gated by clr so a write in flight is dropped on the reset edge
    assign ram_we   = (r_state == WR) & ~clr;
    assign ram_addr = w_mar[ADDR_W-1:0];
    assign ram_din  = w_mdr;

endmodule

// File: tb/tb_mem_interface.sv
// ----------------------------------------------------------------------------
// tb_mem_interface
// Self-checking bench for mem_interface with a behavioural 256-word
// synchronous-read RAM and a scoreboard of expected completions.
// ----------------------------------------------------------------------------
module tb_mem_interface;
    import mem_if_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 8;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    mem_interface_if #(.DATA_W(DW)) bus_if ();

    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic          ram_we;

    mem_interface #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk      (clk),
        .clr      (clr),
        .bus      (bus_if),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_dout (ram_dout)
    );

    // Behavioural RAM: registered read, write at the edge
    logic [DW-1:0] ram     [256];
    logic [DW-1:0] ref_mem [256];
    int            we_count = 0;

    always @(posedge clk) begin
        if (ram_we) begin
            ram[ram_addr] <= ram_din;
            we_count      <= we_count + 1;
        end
        ram_dout <= ram[ram_addr];
    end

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [DW-1:0] seed_word(input int i);
        return (DW'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.bus_in  = '0;
        bus_if.mar_in  = 1'b0;
        bus_if.mdr_in  = 1'b0;
        bus_if.mem_req = 1'b0;
        bus_if.mem_rw  = MEM_READ;
    endtask

    task automatic load_mar(input logic [DW-1:0] v);
        bus_if.bus_in = v;
        bus_if.mar_in = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic load_mdr(input logic [DW-1:0] v);
        bus_if.bus_in = v;
        bus_if.mdr_in = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic request(input logic rw);
        bus_if.mem_req = 1'b1;
        bus_if.mem_rw  = rw;
        tick();
        idle_inputs();
    endtask

    // Bounded wait for mem_done; lat is the cycle index relative to the req cycle
    task automatic wait_done(input int start, output int lat);
        lat = start;
        while (bus_if.mem_done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        clr = 1'b1;
        idle_inputs();
        tick();
        tick();
        clr = 1'b0;
        checks++; if (bus_if.mem_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus_if.mem_busy); end
        checks++; if (bus_if.mem_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus_if.mem_done); end
        checks++; if (bus_if.mem_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus_if.mem_err); end
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", ram_we); end
        checks++; if (bus_if.mdr_out !== '0) begin failures++; $display("FAIL reset_mdr got=%h exp=0", bus_if.mdr_out); end
        checks++; if (ram_addr !== '0) begin failures++; $display("FAIL reset_addr got=%h exp=0", ram_addr); end
    endtask

    task automatic test_write_read();
        exp_t e;
        int   lat;
        int   w0;
        load_mar(32'h05);
        load_mdr(32'hDEAD_BEEF);
        w0 = we_count;
        sb.push_back('{32'hDEAD_BEEF, 1'b0, 2});
        request(MEM_WRITE);
        checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL wr_we got=%b exp=1", ram_we); end
        checks++; if (ram_addr !== 8'h05) begin failures++; $display("FAIL wr_addr got=%h exp=05", ram_addr); end
        checks++; if (ram_din !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_din got=%h exp=deadbeef", ram_din); end
        ref_mem[8'h05] = 32'hDEAD_BEEF;
        wait_done(1, lat);
        e = sb.pop_front();
        checks++; if (lat !== e.lat) begin failures++; $display("FAIL wr_latency got=%0d exp=%0d", lat, e.lat); end
        checks++; if (bus_if.mdr_out !== e.data) begin failures++; $display("FAIL wr_mdr got=%h exp=%h", bus_if.mdr_out, e.data); end
        checks++; if (bus_if.mem_err !== e.err) begin failures++; $display("FAIL wr_err got=%b exp=%b", bus_if.mem_err, e.err); end
        tick();
        checks++; if (bus_if.mem_done !== 1'b0) begin failures++; $display("FAIL wr_done_width got=%b exp=0", bus_if.mem_done); end
        checks++; if (we_count - w0 !== 1) begin failures++; $display("FAIL wr_we_pulses got=%0d exp=1", we_count - w0); end
        load_mdr(32'h0);
        sb.push_back('{ref_mem[8'h05], 1'b0, 3});
        request(MEM_READ);
        wait_done(1, lat);
        e = sb.pop_front();
        checks++; if (lat !== e.lat) begin failures++; $display("FAIL rd_latency got=%0d exp=%0d", lat, e.lat); end
        checks++; if (bus_if.mdr_out !== e.data) begin failures++; $display("FAIL rd_mdr got=%h exp=%h", bus_if.mdr_out, e.data); end
        tick();
    endtask

    task automatic test_wrap();
        exp_t e;
        int   lat;
        int   w0;
        load_mar(32'h1FF);
        load_mdr(32'h0BAD_F00D);
        w0 = we_count;
`ifdef MEM_BOUNDS_CHECK_EN
        sb.push_back('{32'h0BAD_F00D, 1'b1, 1});
`else
        sb.push_back('{ref_mem[8'hFF], 1'b0, 3});
`endif
        request(MEM_READ);
        checks++; if (ram_addr !== 8'hFF) begin failures++; $display("FAIL wrap_addr got=%h exp=ff", ram_addr); end
        wait_done(1, lat);
        e = sb.pop_front();
        checks++; if (lat !== e.lat) begin failures++; $display("FAIL wrap_latency got=%0d exp=%0d", lat, e.lat); end
        checks++; if (bus_if.mdr_out !== e.data) begin failures++; $display("FAIL wrap_mdr got=%h exp=%h", bus_if.mdr_out, e.data); end
        checks++; if (bus_if.mem_err !== e.err) begin failures++; $display("FAIL wrap_err got=%b exp=%b", bus_if.mem_err, e.err); end
        tick();
        checks++; if (we_count !== w0) begin failures++; $display("FAIL wrap_no_write got=%0d exp=%0d", we_count, w0); end
        checks++; if (bus_if.mem_busy !== 1'b0) begin failures++; $display("FAIL wrap_idle got=%b exp=0", bus_if.mem_busy); end
    endtask

    task automatic test_busy_ignore();
        exp_t e;
        int   lat;
        int   w0;
        int   n;
        load_mar(32'h10);
        load_mdr(32'h0);
        w0 = we_count;
        sb.push_back('{ref_mem[8'h10], 1'b0, 3});
        request(MEM_READ);
        bus_if.bus_in  = 32'h1234_5678;
        bus_if.mdr_in  = 1'b1;
        bus_if.mar_in  = 1'b1;
        bus_if.mem_req = 1'b1;
        bus_if.mem_rw  = MEM_WRITE;
        tick();
        idle_inputs();
        checks++; if (bus_if.mdr_out !== 32'h0) begin failures++; $display("FAIL busy_mdr_stable got=%h exp=0", bus_if.mdr_out); end
        checks++; if (ram_addr !== 8'h10) begin failures++; $display("FAIL busy_mar_stable got=%h exp=10", ram_addr); end
        wait_done(2, lat);
        e = sb.pop_front();
        checks++; if (lat !== e.lat) begin failures++; $display("FAIL busy_latency got=%0d exp=%0d", lat, e.lat); end
        checks++; if (bus_if.mdr_out !== e.data) begin failures++; $display("FAIL busy_mdr got=%h exp=%h", bus_if.mdr_out, e.data); end
        n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus_if.mem_done === 1'b1) n++;
        end
        checks++; if (n !== 0) begin failures++; $display("FAIL busy_extra_done got=%0d exp=0", n); end
        checks++; if (we_count !== w0) begin failures++; $display("FAIL busy_no_write got=%0d exp=%0d", we_count, w0); end
    endtask

    task automatic test_clr_abort();
        exp_t e;
        int   lat;
        int   w0;
        int   n;
        load_mar(32'h20);
        load_mdr(32'hCAFE_F00D);
        w0 = we_count;
        request(MEM_WRITE);
        checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL clr_we_before got=%b exp=1", ram_we); end
        clr = 1'b1;
        #1;
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL clr_we_gated got=%b exp=0", ram_we); end
        tick();
        clr = 1'b0;
        checks++; if (bus_if.mem_busy !== 1'b0) begin failures++; $display("FAIL clr_busy got=%b exp=0", bus_if.mem_busy); end
        checks++; if (bus_if.mem_done !== 1'b0) begin failures++; $display("FAIL clr_done got=%b exp=0", bus_if.mem_done); end
        checks++; if (bus_if.mdr_out !== '0) begin failures++; $display("FAIL clr_mdr got=%h exp=0", bus_if.mdr_out); end
        checks++; if (ram_addr !== '0) begin failures++; $display("FAIL clr_addr got=%h exp=0", ram_addr); end
        checks++; if (we_count !== w0) begin failures++; $display("FAIL clr_no_write got=%0d exp=%0d", we_count, w0); end
        n = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus_if.mem_done === 1'b1) n++;
        end
        checks++; if (n !== 0) begin failures++; $display("FAIL clr_no_done got=%0d exp=0", n); end
        load_mar(32'h20);
        sb.push_back('{ref_mem[8'h20], 1'b0, 3});
        request(MEM_READ);
        wait_done(1, lat);
        e = sb.pop_front();
        checks++; if (lat !== e.lat) begin failures++; $display("FAIL clr_rd_latency got=%0d exp=%0d", lat, e.lat); end
        checks++; if (bus_if.mdr_out !== e.data) begin failures++; $display("FAIL clr_old_value got=%h exp=%h", bus_if.mdr_out, e.data); end
        tick();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        load_mar(32'h30);
        load_mdr(32'h600D_CAFE);
        sb.push_back('{32'h600D_CAFE, 1'b0, 2});
        request(MEM_WRITE);
        ref_mem[8'h30] = 32'h600D_CAFE;
        wait_done(1, lat);
        e = sb.pop_front();
        checks++; if (lat !== e.lat) begin failures++; $display("FAIL b2b_wr_latency got=%0d exp=%0d", lat, e.lat); end
        tick();
        // first IDLE cycle after mem_done: read with a same-cycle MAR load
        bus_if.bus_in = 32'h31;
        bus_if.mar_in = 1'b1;
        sb.push_back('{ref_mem[8'h31], 1'b0, 3});
        request(MEM_READ);
        checks++; if (bus_if.mem_busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", bus_if.mem_busy); end
        checks++; if (ram_addr !== 8'h31) begin failures++; $display("FAIL b2b_addr got=%h exp=31", ram_addr); end
        wait_done(1, lat);
        e = sb.pop_front();
        checks++; if (lat !== e.lat) begin failures++; $display("FAIL b2b_rd_latency got=%0d exp=%0d", lat, e.lat); end
        checks++; if (bus_if.mdr_out !== e.data) begin failures++; $display("FAIL b2b_rd_mdr got=%h exp=%h", bus_if.mdr_out, e.data); end
        tick();
    endtask

    task automatic test_same_cycle_load();
        exp_t e;
        int   lat;
        bus_if.bus_in = 32'h42;
        bus_if.mar_in = 1'b1;
        bus_if.mdr_in = 1'b1;
        sb.push_back('{32'h42, 1'b0, 2});
        request(MEM_WRITE);
        checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL same_we got=%b exp=1", ram_we); end
        checks++; if (ram_addr !== 8'h42) begin failures++; $display("FAIL same_addr got=%h exp=42", ram_addr); end
        checks++; if (ram_din !== 32'h42) begin failures++; $display("FAIL same_din got=%h exp=42", ram_din); end
        ref_mem[8'h42] = 32'h42;
        wait_done(1, lat);
        e = sb.pop_front();
        checks++; if (lat !== e.lat) begin failures++; $display("FAIL same_latency got=%0d exp=%0d", lat, e.lat); end
        tick();
        load_mdr(32'h0);
        sb.push_back('{ref_mem[8'h42], 1'b0, 3});
        request(MEM_READ);
        wait_done(1, lat);
        e = sb.pop_front();
        checks++; if (bus_if.mdr_out !== e.data) begin failures++; $display("FAIL same_readback got=%h exp=%h", bus_if.mdr_out, e.data); end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = seed_word(i);
            ref_mem[i] = seed_word(i);
        end
        clr = 1'b1;
        idle_inputs();
        test_reset();
        test_write_read();
        test_wrap();
        test_busy_ignore();
        test_clr_abort();
        test_back_to_back();
        test_same_cycle_load();
        checks++; if (sb.size() !== 0) begin failures++; $display("FAIL scoreboard_drain got=%0d exp=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
